// File: rtl/ddio_out_bus_if.sv
// ddio_out_bus_if: data, enable and status bundle of the DDR output bus
interface ddio_out_bus_if #(
    parameter int WIDTH = 8
);
    logic             clkena;
    logic [WIDTH-1:0] datain_h;
    logic [WIDTH-1:0] datain_l;
    logic             oe;
    logic             train_req;
    logic             train_busy;
    logic [WIDTH-1:0] dataout;
    logic             oe_out;
    modport master (
        output clkena, datain_h, datain_l, oe, train_req,
        input  train_busy, dataout, oe_out
    );
    modport slave (
        input  clkena, datain_h, datain_l, oe, train_req,
        output train_busy, dataout, oe_out
    );
endinterface

// File: rtl/ddio_out_bus.sv
// ddio_out_bus: DDR output bus with tristate pads; training burst FSM present only with DDIO_OUT_BUS_TRAIN_EN
module ddio_out_bus #(
    parameter int    WIDTH             = 8,
    parameter string OUTPUT_RESET      = "clear",
    parameter string EXTEND_OE_DISABLE = "false",
    parameter int    TRAIN_CYCLES      = 16
) (
    input  logic             clk,
    input  logic             sreset,
    ddio_out_bus_if.slave    bus,
    inout  wire  [WIDTH-1:0] padio
);
    localparam logic [WIDTH-1:0] RST_VAL = (OUTPUT_RESET == "preset") ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    localparam bit               EXT_OE  = (EXTEND_OE_DISABLE == "true");
    logic [WIDTH-1:0] reg_h_q, reg_h_d, reg_l_q, reg_l_d, reg_l_n_q, reg_l_n_d;
    logic             oe_q, oe_d, oe_n_q, oe_n_d;
    logic             train;
`ifdef DDIO_OUT_BUS_TRAIN_EN
    typedef enum logic {IDLE, TRAIN} state_t;
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       treq_q, treq_d;
    logic       last;
    always_comb begin
        last    = cnt_q == 8'(TRAIN_CYCLES - 1);
        treq_d  = bus.train_req;
        state_d = train ? (last ? IDLE : TRAIN) : ((bus.train_req && !treq_q) ? TRAIN : IDLE);
        cnt_d   = (train && !last) ? cnt_q + 8'd1 : 8'd0;
    end
    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            treq_q  <= 1'b0;
        end else if (bus.clkena) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            treq_q  <= treq_d;
        end
    end
    assign train          = state_q == TRAIN;
    assign bus.train_busy = train;
`else
    wire unused_train_req = bus.train_req;
    assign train          = 1'b0;
    assign bus.train_busy = 1'b0;
`endif
    always_comb begin
        reg_h_d   = train ? {WIDTH{1'b1}} : bus.datain_h;
        reg_l_d   = train ? {WIDTH{1'b0}} : bus.datain_l;
        oe_d      = train | bus.oe;
        reg_l_n_d = reg_l_q;
        oe_n_d    = oe_q;
    end
    always_ff @(posedge clk) begin
        if (sreset) begin
            reg_h_q <= RST_VAL;
            reg_l_q <= RST_VAL;
            oe_q    <= 1'b0;
        end else if (bus.clkena) begin
            reg_h_q <= reg_h_d;
            reg_l_q <= reg_l_d;
            oe_q    <= oe_d;
        end
    end
    always_ff @(negedge clk) begin
        if (sreset) begin
            reg_l_n_q <= RST_VAL;
            oe_n_q    <= 1'b0;
        end else begin
            reg_l_n_q <= reg_l_n_d;
            oe_n_q    <= oe_n_d;
        end
    end
    assign bus.dataout = clk ? reg_h_q : reg_l_n_q;
    assign bus.oe_out  = EXT_OE ? (oe_q & oe_n_q) : oe_q;
    assign padio       = bus.oe_out ? bus.dataout : {WIDTH{1'bz}};
endmodule

// File: doc/ddio_out_bus.md
DDIO_OUT_BUS -- requirements
Module: ddio_out_bus

Interface
REQ-001 Parameter WIDTH, default 8, number of DDR output channels (1..64).
REQ-002 Parameter OUTPUT_RESET, default "clear", data-register reset value ("clear" = all 0, "preset" = all 1).
REQ-003 Parameter EXTEND_OE_DISABLE, default "false", "true" delays OE assertion by half a clock.
REQ-004 Parameter TRAIN_CYCLES, default 16, length of the training burst in enabled cycles (1..255).
REQ-005 Port clk  input  1  single clock; rising and falling edges are both used.
REQ-006 Port sreset  input  1  synchronous, active-high reset.
REQ-007 Port clkena  input  1  clock enable for data/OE capture, FSM and counter.
REQ-008 Port datain_h  input  WIDTH  data driven during the clk-high phase.
REQ-009 Port datain_l  input  WIDTH  data driven during the clk-low phase.
REQ-010 Port oe  input  1  output enable request, active-high.
REQ-011 Port train_req  input  1  training burst request, rising-edge triggered.
REQ-012 Port train_busy  output  1  high while the training burst runs.
REQ-013 Port dataout  output  WIDTH  DDR data stream before the tristate.
REQ-014 Port oe_out  output  1  effective registered output enable.
REQ-015 Port padio  inout  WIDTH  equals dataout when oe_out=1, else high-Z.

Function
REQ-016 At a rising clk edge with clkena=1 and state IDLE: reg_h<=datain_h, reg_l<=datain_l, oe_reg<=oe.
REQ-017 At every falling clk edge: reg_l_n<=reg_l, oe_n<=oe_reg.
REQ-018 dataout SHALL be reg_h while clk=1 and reg_l_n while clk=0, glitch-free per phase.
REQ-019 Latency: datain_h sampled at rising edge k appears in the high phase after edge k; datain_l sampled at edge k appears in the following low phase.
REQ-020 With clkena=0 all rising-edge registers, FSM and counter hold; falling-edge retiming continues.
REQ-021 EXTEND_OE_DISABLE="false": oe_out=oe_reg; "true": oe_out=oe_reg AND oe_n, so assertion is delayed half a cycle and deassertion is immediate.
REQ-022 FSM states IDLE and TRAIN; IDLE->TRAIN when clkena=1 and train_req=1 while train_req_d=0 (train_req_d registered each enabled cycle).
REQ-023 In TRAIN: reg_h<=all ones, reg_l<=all zeros, oe_reg<=1, counter increments per enabled cycle; datain_h/datain_l/oe are ignored.
REQ-024 TRAIN->IDLE on the enabled cycle where counter=TRAIN_CYCLES-1; counter clears to 0; exactly TRAIN_CYCLES 1/0 periods are emitted.
REQ-025 train_busy=1 exactly while the state is TRAIN (registered).
REQ-026 train_req held high across a burst SHALL NOT retrigger; a new burst requires a low-to-high transition observed in IDLE.
REQ-027 A train_req edge arriving during TRAIN is discarded, not queued.
REQ-028 On the first IDLE cycle after TRAIN, the capture of REQ-016 resumes in the same cycle.

Reset
REQ-029 sreset=1 at a rising edge takes effect regardless of clkena: reg_h, reg_l = OUTPUT_RESET value; oe_reg=0; state IDLE; counter=0; train_req_d=0; train_busy=0.
REQ-030 sreset=1 at a falling edge: reg_l_n = OUTPUT_RESET value; oe_n=0.
REQ-031 sreset asserted mid-burst aborts training; after release, a fresh train_req rising edge is required.

Configuration
REQ-032 Macro DDIO_OUT_BUS_TRAIN_EN defined: FSM, counter and training behaviour present as specified.
REQ-033 Macro DDIO_OUT_BUS_TRAIN_EN undefined: no FSM or counter logic; train_req ignored; train_busy tied 0; REQ-016 always applies.

Verification
REQ-034 WIDTH=8, datain_h=8'hA5, datain_l=8'h3C, oe=1, clkena=1 -> dataout is A5 in the high phase and 3C in the low phase after the next edge, and padio matches.
REQ-035 clkena=0 for 3 cycles with changing inputs -> dataout pattern and oe_out are frozen at their prior values.
REQ-036 EXTEND_OE_DISABLE="true", oe 0->1->0 -> oe_out rises half a cycle after oe_reg and falls with oe_reg; with "false" it tracks oe_reg.
REQ-037 TRAIN_CYCLES=4, single-cycle train_req pulse -> train_busy high for exactly 4 cycles, dataout FF/00 per phase, oe_out=1, then normal data.
REQ-038 train_req held high 10 cycles with TRAIN_CYCLES=4 -> exactly one burst; sreset during cycle 2 of a burst -> train_busy=0, dataout = reset value (00 for "clear", FF for "preset").
